// File: rtl/gbt_link_sequencer.sv
// -----------------------------------------------------------------------------
// gbt_link_sequencer
//
// Bring-up and recovery sequencer for the GBT transceiver bank, running in the
// 40 MHz management clock domain. It pulses the bank's general reset and the
// manual RX reset, waits for the TX and RX ready flags, and retries with
// bounded timeouts until the link is up. Loss of signal, loss of either ready
// flag, or a forced restart sends the sequence back to the right point.
//
// Ports
//   clk_ik                 in   40 MHz management clock
//   rst_n_ir               in   synchronous active-low reset
//   sfp_los_i              in   SFP loss of signal (asynchronous)
//   tx_ready_i             in   bank TX ready (asynchronous)
//   rx_ready_i             in   bank RX ready (asynchronous)
//   force_reset_i          in   synchronous request to restart from GENRST
//   gbt_general_reset_o    out  general reset to the bank, active-high
//   gbt_manual_reset_rx_o  out  RX reset to the bank, active-high
//   link_up_o              out  link operational
//   link_lost_o            out  one-clock pulse when leaving UP
//   retry_cnt_o   [7:0]    out  saturating timeout/recovery counter
//   state_o       [2:0]    out  current state encoding
// -----------------------------------------------------------------------------
module gbt_link_sequencer #(
  parameter int RST_CYCLES = 64,
  parameter int TX_TIMEOUT = 40000,
  parameter int RX_TIMEOUT = 400000,
  parameter int LOS_FILTER = 1024
) (
  input  logic       clk_ik,
  input  logic       rst_n_ir,
  input  logic       sfp_los_i,
  input  logic       tx_ready_i,
  input  logic       rx_ready_i,
  input  logic       force_reset_i,
  output logic       gbt_general_reset_o,
  output logic       gbt_manual_reset_rx_o,
  output logic       link_up_o,
  output logic       link_lost_o,
  output logic [7:0] retry_cnt_o,
  output logic [2:0] state_o
);

  localparam int MAX_A = (RST_CYCLES > TX_TIMEOUT) ? RST_CYCLES : TX_TIMEOUT;
  localparam int MAX_B = (RX_TIMEOUT > LOS_FILTER) ? RX_TIMEOUT : LOS_FILTER;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TMR_W = $clog2(MAX_P + 1);

  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TX_LAST  = TMR_W'(TX_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] RX_LAST  = TMR_W'(RX_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LOS_LAST = TMR_W'(LOS_FILTER - 1);

  typedef enum logic [2:0] {
    S_LOS    = 3'd0,
    S_GENRST = 3'd1,
    S_WAITTX = 3'd2,
    S_RXRST  = 3'd3,
    S_WAITRX = 3'd4,
    S_UP     = 3'd5
  } state_t;

  // Saturating increments: neither the timer nor the retry counter may wrap.
  function automatic logic [TMR_W-1:0] tmr_inc(input logic [TMR_W-1:0] v);
    return (v == {TMR_W{1'b1}}) ? v : v + TMR_W'(1);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic             los_p0, txr_p0, rxr_p0;
  logic             los_s, txr_s, rxr_s;
  state_t           state_q, state_nxt;
  logic [TMR_W-1:0] tmr_q;
  logic             tmr_clr;
  logic             retry_inc;
  logic             lost_nxt;

  // ---- stage p0 -> s: two-flop synchronisers for the asynchronous flags ----
  always_ff @(posedge clk_ik) begin
    if (!rst_n_ir) begin
      los_p0 <= 1'b0;
      txr_p0 <= 1'b0;
      rxr_p0 <= 1'b0;
      los_s  <= 1'b0;
      txr_s  <= 1'b0;
      rxr_s  <= 1'b0;
    end else begin
      los_p0 <= sfp_los_i;
      txr_p0 <= tx_ready_i;
      rxr_p0 <= rx_ready_i;
      los_s  <= los_p0;
      txr_s  <= txr_p0;
      rxr_s  <= rxr_p0;
    end
  end

  always_comb begin
    state_nxt = state_q;
    tmr_clr   = 1'b0;
    retry_inc = 1'b0;
    lost_nxt  = 1'b0;

    // Loss of signal outranks everything; while already in LOS this keeps the
    // filter timer pinned at zero so only an unbroken LOS-free run counts.
    if (los_s) begin
      state_nxt = S_LOS;
      tmr_clr   = 1'b1;
    end else if (force_reset_i) begin
      // Re-entering GENRST restarts the pulse, so a held force keeps the
      // general reset asserted.
      state_nxt = S_GENRST;
      tmr_clr   = 1'b1;
    end else begin
      case (state_q)
        S_LOS:    if (tmr_q == LOS_LAST) state_nxt = S_GENRST;
        S_GENRST: if (tmr_q == RST_LAST) state_nxt = S_WAITTX;
        S_WAITTX: begin
          // Ready is checked first so it wins on the timeout clock.
          if (txr_s) begin
            state_nxt = S_RXRST;
          end else if (tmr_q == TX_LAST) begin
            state_nxt = S_GENRST;
            retry_inc = 1'b1;
          end
        end
        S_RXRST:  if (tmr_q == RST_LAST) state_nxt = S_WAITRX;
        S_WAITRX: begin
          if (rxr_s) begin
            state_nxt = S_UP;
          end else if (tmr_q == RX_LAST) begin
            state_nxt = S_RXRST;
            retry_inc = 1'b1;
          end
        end
        S_UP: begin
          if (!txr_s)      state_nxt = S_GENRST;
          else if (!rxr_s) state_nxt = S_RXRST;
        end
        default:          state_nxt = S_GENRST;
      endcase
    end

    // Any way out of UP, including the overrides, is a lost link.
    if ((state_q == S_UP) && (state_nxt != S_UP)) begin
      lost_nxt  = 1'b1;
      retry_inc = 1'b1;
    end

    if (state_nxt != state_q) tmr_clr = 1'b1;
  end

  always_ff @(posedge clk_ik) begin
    if (!rst_n_ir) begin
      state_q <= S_GENRST;
      tmr_q   <= '0;
    end else begin
      state_q <= state_nxt;
      tmr_q   <= tmr_clr ? '0 : tmr_inc(tmr_q);
    end
  end

  // ---- registered outputs, decoded from the next state ----
  always_ff @(posedge clk_ik) begin
    if (!rst_n_ir) begin
      gbt_general_reset_o   <= 1'b1;
      gbt_manual_reset_rx_o <= 1'b0;
      link_up_o             <= 1'b0;
      link_lost_o           <= 1'b0;
      retry_cnt_o           <= 8'd0;
      state_o               <= 3'd1;
    end else begin
      gbt_general_reset_o   <= (state_nxt == S_LOS) || (state_nxt == S_GENRST);
      gbt_manual_reset_rx_o <= (state_nxt == S_RXRST);
      link_up_o             <= (state_nxt == S_UP);
      link_lost_o           <= lost_nxt;
      retry_cnt_o           <= retry_inc ? sat_inc8(retry_cnt_o) : retry_cnt_o;
      state_o               <= state_nxt;
    end
  end

endmodule

// File: tb/tb_gbt_link_sequencer.sv
module tb_gbt_link_sequencer;

  localparam int RST_CYCLES = 8;
  localparam int TX_TIMEOUT = 100;
  localparam int RX_TIMEOUT = 200;
  localparam int LOS_FILTER = 16;

  localparam int ST_LOS = 0, ST_GEN = 1, ST_WTX = 2, ST_RXR = 3, ST_WRX = 4, ST_UP = 5;

  logic       clk;
  logic       rst_n_ir;
  logic       sfp_los_i, tx_ready_i, rx_ready_i, force_reset_i;
  logic       gbt_general_reset_o, gbt_manual_reset_rx_o;
  logic       link_up_o, link_lost_o;
  logic [7:0] retry_cnt_o;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  gbt_link_sequencer #(
    .RST_CYCLES(RST_CYCLES),
    .TX_TIMEOUT(TX_TIMEOUT),
    .RX_TIMEOUT(RX_TIMEOUT),
    .LOS_FILTER(LOS_FILTER)
  ) dut (
    .clk_ik               (clk),
    .rst_n_ir             (rst_n_ir),
    .sfp_los_i            (sfp_los_i),
    .tx_ready_i           (tx_ready_i),
    .rx_ready_i           (rx_ready_i),
    .force_reset_i        (force_reset_i),
    .gbt_general_reset_o  (gbt_general_reset_o),
    .gbt_manual_reset_rx_o(gbt_manual_reset_rx_o),
    .link_up_o            (link_up_o),
    .link_lost_o          (link_lost_o),
    .retry_cnt_o          (retry_cnt_o),
    .state_o              (state_o)
  );

  initial begin
    clk = 1'b0;
    forever #12 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Reference model: the pins reach the sequence two clocks late, each state
  // is left after its dwell time, and the expected output word for every clock
  // is queued for the monitor.
  // ---------------------------------------------------------------------------
  logic [14:0] exp_q[$];
  bit          los_dq[$], tx_dq[$], rx_dq[$];
  bit          m_on = 1'b0;
  int          m_st, m_nx, m_tm, m_retry;
  bit          m_lost, m_inc, m_restart, m_ls, m_ts, m_rs;

  always @(posedge clk) begin
    if (!rst_n_ir) begin
      m_st = ST_GEN; m_tm = 0; m_retry = 0; m_lost = 1'b0;
      los_dq = '{1'b0, 1'b0};
      tx_dq  = '{1'b0, 1'b0};
      rx_dq  = '{1'b0, 1'b0};
      m_on = 1'b1;
    end else if (m_on) begin
      m_ls = los_dq.pop_front(); los_dq.push_back(sfp_los_i);
      m_ts = tx_dq.pop_front();  tx_dq.push_back(tx_ready_i);
      m_rs = rx_dq.pop_front();  rx_dq.push_back(rx_ready_i);
      m_nx = m_st; m_restart = 1'b0; m_inc = 1'b0;
      if (m_ls) begin
        m_nx = ST_LOS; m_restart = 1'b1;
      end else if (force_reset_i) begin
        m_nx = ST_GEN; m_restart = 1'b1;
      end else begin
        case (m_st)
          ST_LOS: if (m_tm + 1 == LOS_FILTER) m_nx = ST_GEN;
          ST_GEN: if (m_tm + 1 == RST_CYCLES) m_nx = ST_WTX;
          ST_WTX: if (m_ts) m_nx = ST_RXR;
                  else if (m_tm + 1 == TX_TIMEOUT) begin m_nx = ST_GEN; m_inc = 1'b1; end
          ST_RXR: if (m_tm + 1 == RST_CYCLES) m_nx = ST_WRX;
          ST_WRX: if (m_rs) m_nx = ST_UP;
                  else if (m_tm + 1 == RX_TIMEOUT) begin m_nx = ST_RXR; m_inc = 1'b1; end
          ST_UP:  if (!m_ts) m_nx = ST_GEN;
                  else if (!m_rs) m_nx = ST_RXR;
          default: m_nx = ST_GEN;
        endcase
      end
      m_lost = (m_st == ST_UP) && (m_nx != ST_UP);
      if (m_lost) m_inc = 1'b1;
      if (m_inc && m_retry < 255) m_retry = m_retry + 1;
      m_tm = (m_restart || m_nx != m_st) ? 0 : m_tm + 1;
      m_st = m_nx;
    end
    if (m_on)
      exp_q.push_back({(m_st == ST_LOS) || (m_st == ST_GEN), m_st == ST_RXR, m_st == ST_UP,
                       m_lost, 8'(m_retry), 3'(m_st)});
  end

  // Monitor: the DUT presents a new output word every clock.
  logic [14:0] exp_v, act_v;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {gbt_general_reset_o, gbt_manual_reset_rx_o, link_up_o, link_lost_o,
               retry_cnt_o, state_o};
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL outputs cycle %0d: got gen=%b rx=%b up=%b lost=%b retry=%0d state=%0d, required gen=%b rx=%b up=%b lost=%b retry=%0d state=%0d",
                   cyc, act_v[14], act_v[13], act_v[12], act_v[11], act_v[10:3], act_v[2:0],
                   exp_v[14], exp_v[13], exp_v[12], exp_v[11], exp_v[10:3], exp_v[2:0]);
      end
    end
  end

  initial begin
    #(60000 * 24);
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic wait_state(input int want, input int budget, input string name);
    int k;
    k = 0;
    while (int'(state_o) != want && k < budget) begin step(); k++; end
    chk(name, int'(state_o), want);
  endtask

  task automatic reset_pulse();
    rst_n_ir = 1'b0;
    step();
    rst_n_ir = 1'b1;
  endtask

  int gen_cnt, rx_cnt, lost_cnt, lost_idx, st_at_lost, bad, first, k;

  initial begin
    rst_n_ir = 1'b0; sfp_los_i = 1'b0; tx_ready_i = 1'b0; rx_ready_i = 1'b0; force_reset_i = 1'b0;
    repeat (3) step();
    chk("reset_state", int'(state_o), 1);
    chk("reset_genrst", int'(gbt_general_reset_o), 1);
    chk("reset_rxrst", int'(gbt_manual_reset_rx_o), 0);
    chk("reset_up_lost_retry", int'({link_up_o, link_lost_o, retry_cnt_o}), 0);

    // Nominal bring-up.
    rst_n_ir = 1'b1;
    gen_cnt = 0; rx_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (gbt_general_reset_o) gen_cnt++;
      if (gbt_manual_reset_rx_o) rx_cnt++;
      step();
      if (i + 1 == 20) tx_ready_i = 1'b1;
      if (i + 1 == 30) rx_ready_i = 1'b1;
    end
    chk("nominal_genrst_width", gen_cnt, RST_CYCLES);
    chk("nominal_rxrst_width", rx_cnt, RST_CYCLES);
    chk("nominal_state", int'(state_o), ST_UP);
    chk("nominal_link_up", int'(link_up_o), 1);
    chk("nominal_retry", int'(retry_cnt_o), 0);

    // RX ready drops while UP.
    rx_ready_i = 1'b0;
    gen_cnt = 0; rx_cnt = 0; lost_cnt = 0; lost_idx = -1; st_at_lost = -1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (gbt_general_reset_o) gen_cnt++;
      if (gbt_manual_reset_rx_o) rx_cnt++;
      if (link_lost_o) begin lost_cnt++; lost_idx = i; st_at_lost = int'(state_o); end
      step();
      if (i == 4) rx_ready_i = 1'b1;
    end
    chk("rxloss_lost_pulses", lost_cnt, 1);
    chk("rxloss_latency", lost_idx, 3);
    chk("rxloss_state", st_at_lost, ST_RXR);
    chk("rxloss_rxrst_width", rx_cnt, RST_CYCLES);
    chk("rxloss_no_genrst", gen_cnt, 0);
    chk("rxloss_retry", int'(retry_cnt_o), 1);
    chk("rxloss_recovered", int'(state_o), ST_UP);

    // LOS and force reach the sequence on the same clock while UP.
    sfp_los_i = 1'b1;
    lost_cnt = 0; lost_idx = -1; st_at_lost = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (link_lost_o) begin lost_cnt++; lost_idx = i; st_at_lost = int'(state_o); end
      step();
      if (i == 1) force_reset_i = 1'b1;
    end
    force_reset_i = 1'b0;
    chk("simul_lost_pulses", lost_cnt, 1);
    chk("simul_state_at_lost", st_at_lost, ST_LOS);
    chk("simul_state", int'(state_o), ST_LOS);
    chk("simul_retry", int'(retry_cnt_o), 2);

    // LOS filter: short gaps never release the sequence.
    bad = 0;
    for (int p = 0; p < 5; p++)
      for (int j = 0; j < 12; j++) begin
        sfp_los_i = (j >= 2);
        @(negedge clk);
        if (state_o != 3'd0) bad++;
        step();
      end
    chk("los_filter_hold", bad, 0);
    sfp_los_i = 1'b0;
    first = 0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (first == 0 && state_o != 3'd0) first = k;
      step();
    end
    chk("los_release_clocks", first, LOS_FILTER + 3);
    wait_state(ST_UP, 100, "los_recover_up");

    // Force held high while UP.
    force_reset_i = 1'b1;
    bad = 0; lost_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!gbt_general_reset_o) bad++;
      if (link_lost_o) lost_cnt++;
    end
    force_reset_i = 1'b0;
    chk("force_genrst_held", bad, 0);
    chk("force_lost_pulses", lost_cnt, 1);
    chk("force_retry", int'(retry_cnt_o), 3);
    wait_state(ST_UP, 100, "force_recover_up");

    // RX ready lost for good: one loss plus one RX timeout, then reset in WAITRX.
    rx_ready_i = 1'b0;
    k = 0;
    while (retry_cnt_o != 8'd5 && k < 400) begin step(); k++; end
    chk("rxtimeout_retry", int'(retry_cnt_o), 5);
    wait_state(ST_WRX, 20, "rxtimeout_waitrx");
    tx_ready_i = 1'b0;
    reset_pulse();
    chk("midreset_state", int'(state_o), 1);
    chk("midreset_retry", int'(retry_cnt_o), 0);
    chk("midreset_genrst", int'(gbt_general_reset_o), 1);

    // TX ready arriving exactly on the timeout clock wins.
    repeat (TX_TIMEOUT + RST_CYCLES - 3) step();
    tx_ready_i = 1'b1;
    repeat (2) step();
    chk("tx_edge_still_waiting", int'(state_o), ST_WTX);
    step();
    chk("tx_edge_ready_wins", int'(state_o), ST_RXR);
    chk("tx_edge_no_retry", int'(retry_cnt_o), 0);

    // Randomised pin activity against the model.
    for (int r = 0; r < 150; r++) begin
      int hold;
      hold          = int'($urandom_range(1, 40));
      sfp_los_i     = ($urandom_range(0, 9) == 0);
      tx_ready_i    = ($urandom_range(0, 4) != 0);
      rx_ready_i    = ($urandom_range(0, 4) != 0);
      force_reset_i = ($urandom_range(0, 19) == 0);
      rst_n_ir      = ($urandom_range(0, 29) != 0);
      repeat (hold) begin step(); force_reset_i = 1'b0; rst_n_ir = 1'b1; end
    end

    // TX ready stuck low: the retry count climbs and saturates.
    sfp_los_i = 1'b0; tx_ready_i = 1'b0; rx_ready_i = 1'b0; force_reset_i = 1'b0;
    reset_pulse();
    repeat (254 * (RST_CYCLES + TX_TIMEOUT) + 1) step();
    chk("txtimeout_retry_254", int'(retry_cnt_o), 254);
    repeat (300) step();
    chk("txtimeout_retry_sat", int'(retry_cnt_o), 255);

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gbt_link_sequencer.md
# gbt_link_sequencer

Bring-up and recovery sequencer for the GBT transceiver bank. It drives the bank's general reset and manual RX reset, watches SFP loss-of-signal and the bank's TX/RX ready flags, and retries with bounded timeouts until the link is up. It sits in the 40 MHz management clock domain between the clock/reset tree and the GBT bank, replacing the static reset tie-offs. It also exports link status for diagnostics.

## Interface
- `RST_CYCLES`, 64: width of each reset pulse, in clocks.
- `TX_TIMEOUT`, 40000: clocks allowed for TX ready after the general reset is released.
- `RX_TIMEOUT`, 400000: clocks allowed for RX ready after the RX reset is released.
- `LOS_FILTER`, 1024: consecutive LOS-free clocks required before bring-up starts.
- `clk_ik` in 1: 40 MHz management clock.
- `rst_n_ir` in 1: reset, synchronous, active-low.
- `sfp_los_i` in 1: SFP loss of signal, asynchronous.
- `tx_ready_i` in 1: bank TX ready, asynchronous.
- `rx_ready_i` in 1: bank RX ready, asynchronous.
- `force_reset_i` in 1: synchronous request to restart the full sequence.
- `gbt_general_reset_o` out 1: general reset to the bank, active-high.
- `gbt_manual_reset_rx_o` out 1: RX reset to the bank, active-high.
- `link_up_o` out 1: link operational.
- `link_lost_o` out 1: one-clock pulse when leaving UP.
- `retry_cnt_o` out 8: timeout/recovery counter, saturating.
- `state_o` out 3: current state encoding.

## Operation
- **Input synchronisers.** `sfp_los_i`, `tx_ready_i` and `rx_ready_i` each pass through a 2-FF synchroniser. The FSM sees only the synchronised values (`los_s`, `txr_s`, `rxr_s`).
- **Timer.** One timer, width `$clog2(max(all params)+1)`. It clears to 0 on every state entry and increments each clock while in the state. It never wraps.
- **States** (encoding in parentheses):
  - **LOS (0):** general reset = 1. When `los_s` = 1 the timer holds at 0. When the timer reaches `LOS_FILTER-1` → GENRST.
  - **GENRST (1):** general reset = 1. When the timer reaches `RST_CYCLES-1` → WAITTX.
  - **WAITTX (2):** if `txr_s` = 1 → RXRST. Otherwise, when the timer reaches `TX_TIMEOUT-1` → GENRST and retry +1.
  - **RXRST (3):** RX reset = 1. When the timer reaches `RST_CYCLES-1` → WAITRX.
  - **WAITRX (4):** if `rxr_s` = 1 → UP. Otherwise, when the timer reaches `RX_TIMEOUT-1` → RXRST and retry +1.
  - **UP (5):** `link_up_o` = 1.
- **Exits from UP**, with `link_lost_o` pulsed and retry +1:
  - `los_s` = 1 → LOS.
  - `txr_s` = 0 → GENRST.
  - `rxr_s` = 0 → RXRST.
- **Global overrides**, evaluated before the per-state rules:
  - `los_s` = 1 in any state other than LOS → LOS.
  - Otherwise, `force_reset_i` = 1 → GENRST.
  - Neither increments retry, except when leaving UP.
- **Priority within UP:** los > force > tx loss > rx loss. A forced exit from UP also pulses `link_lost_o`.
- **Retry counter.** Saturates at 255. Cleared only by reset.
- **Encodings 6 and 7** are unused and recover to GENRST on the next clock.

## Timing
- **Outputs.** All outputs are registered and decoded from the next state, so they change in the same clock as the state.
- **Reset values** (`rst_n_ir` = 0 sampled):
  - state = GENRST, timer = 0
  - `gbt_general_reset_o` = 1, `gbt_manual_reset_rx_o` = 0
  - `link_up_o` = 0, `link_lost_o` = 0
  - `retry_cnt_o` = 0, `state_o` = 1
  - synchronisers cleared to 0
- **Reset pulse width.** `gbt_general_reset_o` is high for exactly `RST_CYCLES` clocks per GENRST visit. The same holds for `gbt_manual_reset_rx_o` per RXRST visit.
- **Input latency.** Change at a pin → FSM reaction = 2 clocks of synchroniser + 1 state register = visible on the outputs 3 clocks later.
- **Ready on the timeout clock.** If ready arrives in the same clock as the timeout expiry, ready wins: no retry is counted.
- **Reset mid-operation.** Any state returns to GENRST and all outputs return to their reset values on the next clock. Counts are lost.
- **Force held high.** GENRST re-enters every clock, so the general reset stays asserted and no retry is counted.

## Test plan
- **Nominal bring-up.** Params 8/100/200/16, LOS = 0, raise `tx_ready_i` 20 clocks after release and `rx_ready_i` 30 clocks after release → general reset high exactly 8 clocks, RX reset high 8 clocks, `link_up_o` = 1, retry = 0, `state_o` = 5.
- **TX timeout.** `tx_ready_i` stuck 0 → GENRST re-entered every 8+100 clocks, retry increments each time, saturates at 255 after 255 timeouts.
- **LOS filter.** LOS pulses of 10 clocks every 12 clocks → state stays 0. Then LOS held low → GENRST entered 16+3 clocks after the last falling edge.
- **Link loss.** In UP, drop `rx_ready_i` → 3 clocks later `link_lost_o` pulses once, state = 3, retry +1, RX reset for 8 clocks. The general reset does not assert.
- **Simultaneous events.** In UP, assert LOS and `force_reset_i` together → state = 0 (LOS wins), a single `link_lost_o` pulse.
- **Reset mid-sequence.** Assert `rst_n_ir` = 0 for 1 clock during WAITRX → next clock `state_o` = 1, retry = 0, general reset = 1.
